sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/mem_pkg.sv | 13 +
 rtl/sram_phase_timer.sv | 25 ++
 rtl/sram_controller.sv | 136 +++++++++++++
 tb/tb_sram_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the 32-bit to 16-bit SRAM bridge.
package mem_pkg;
   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;
   localparam int WORD_W      = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } sram_state_t;
endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter that times one SRAM half-access; phase_done marks the last cycle of a phase.
module sram_phase_timer #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic phase_done
);
   localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

   logic [3:0] cnt;

   // Reload while idle and at terminal count so back-to-back phases each get the full count.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= 4'd0;
      else if (!run || cnt == 4'd0)
         cnt <= RELOAD;
      else
         cnt <= cnt - 4'd1;
   end

   assign phase_done = run && (cnt == 4'd0);
endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half, then high half).
// Optional one-entry read cache enabled by defining SRAM_READ_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for read/write; request sampled on exit
// LOW   | low half-word access, WAIT_CYCLES long
// HIGH  | high half-word access, WAIT_CYCLES long
// DONE  | one-cycle completion, stall released
module sram_controller
   import mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   read,
   input  logic                   write,
   input  logic [WORD_W-1:0]      address,
   input  logic [WORD_W-1:0]      writedata,
   output logic [WORD_W-1:0]      readdata,
   output logic                   SRAM_NOT_READY,
   output logic [SRAM_ADDR_W-1:0] SRAMaddress,
   output logic                   SRAMWEn,
   output logic                   SRAMOE,
   inout  wire  [SRAM_DATA_W-1:0] SRAMdata
);
   sram_state_t state, state_nxt;

   logic                   req;
   logic                   run;
   logic                   phase_done;
   logic                   cache_hit;
   logic [WORD_W-1:0]      cache_rdata;
   logic                   is_write_q;
   logic [WORD_W-1:0]      addr_q;
   logic [WORD_W-1:0]      wdata_q;
   logic [SRAM_DATA_W-1:0] low_q;
   logic [WORD_W-1:0]      rdata_q;
   logic [WORD_W-1:0]      off;
   logic                   off_unused;

   assign req = read | write;
   assign run = (state == LOW) || (state == HIGH);

   sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .phase_done (phase_done)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req && !cache_hit) state_nxt = LOW;
         LOW:     if (phase_done) state_nxt = HIGH;
         HIGH:    if (phase_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign SRAM_NOT_READY = ((state == IDLE) && req && !cache_hit) || run;

   // Low half is parked in low_q so readdata only changes once the whole word has arrived.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         low_q      <= '0;
         rdata_q    <= '0;
      end else begin
         if (state == IDLE && state_nxt == LOW) begin
            is_write_q <= write;
            addr_q     <= address;
            wdata_q    <= writedata;
         end
         if (state == LOW && phase_done)
            low_q <= SRAMdata;
         if (state == HIGH && phase_done && !is_write_q)
            rdata_q <= {SRAMdata, low_q};
         else if (cache_hit)
            rdata_q <= cache_rdata;
      end
   end

`ifdef SRAM_READ_CACHE_EN
   logic              cache_valid;
   logic [29:0]       cache_tag;
   logic [WORD_W-1:0] cache_data;

   assign cache_hit   = (state == IDLE) && read && !write && cache_valid
                        && (address[31:2] == cache_tag);
   assign cache_rdata = cache_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_data  <= '0;
      end else begin
         if (state == HIGH && phase_done && !is_write_q) begin
            cache_valid <= 1'b1;
            cache_tag   <= addr_q[31:2];
            cache_data  <= {SRAMdata, low_q};
         end
         if (state == DONE && is_write_q && cache_valid && cache_tag == addr_q[31:2])
            cache_data <= wdata_q;
      end
   end
`else
   assign cache_hit   = 1'b0;
   assign cache_rdata = '0;
`endif

   assign readdata = cache_hit ? cache_rdata : rdata_q;

   assign off        = addr_q - ADDR_BASE;
   assign off_unused = ^{off[31:19], off[1:0]};

   assign SRAMaddress = {off[18:2], state == HIGH};
   assign SRAMWEn     = !(run && is_write_q);
   assign SRAMOE      = !(run && !is_write_q);
   assign SRAMdata    = (run && is_write_q)
                        ? ((state == HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                        : 'z;
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: vector table, reset corner cases and random accesses
// against a word-level memory model with an attached 16-bit SRAM model.
module tb_sram_controller;
   localparam int          W    = 2;
   localparam logic [31:0] BASE = 32'd1024;
   localparam logic [15:0] IDLE_BUS = 16'h5A5A;

   logic        clk = 1'b0;
   logic        rst;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        SRAM_NOT_READY;
   logic [17:0] SRAMaddress;
   logic        SRAMWEn;
   logic        SRAMOE;
   wire  [15:0] SRAMdata;

   logic [15:0] sram [0:262143];

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [int];
   logic [31:0] mdl_last;
   bit          mdl_cv;
   logic [29:0] mdl_tag;
   logic [31:0] mdl_cdata;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [8];

   sram_controller #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
      .clk            (clk),
      .rst            (rst),
      .read           (read),
      .write          (write),
      .address        (address),
      .writedata      (writedata),
      .readdata       (readdata),
      .SRAM_NOT_READY (SRAM_NOT_READY),
      .SRAMaddress    (SRAMaddress),
      .SRAMWEn        (SRAMWEn),
      .SRAMOE         (SRAMOE),
      .SRAMdata       (SRAMdata)
   );

   always #5 clk = ~clk;

   // SRAM drives on read; a marker pattern shows up whenever nobody should be driving.
   assign SRAMdata = (!SRAMOE && SRAMWEn) ? sram[SRAMaddress]
                   : (SRAMWEn ? IDLE_BUS : 16'hzzzz);

   always @(posedge clk)
      if (!SRAMWEn) sram[SRAMaddress] <= SRAMdata;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(((a - BASE) >> 2) & 32'h1FFFF);
   endfunction

   // One complete access; called just after a falling edge with the DUT idle.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input bit scramble);
      int          k;
      int          lat;
      int          exp_lat;
      bit          exp_hit;
      logic [17:0] exp_sa;
      logic [31:0] exp_rd;
      k       = widx(a);
      exp_hit = 1'b0;
`ifdef SRAM_READ_CACHE_EN
      exp_hit = rd && !wr && mdl_cv && (mdl_tag == a[31:2]);
`endif
      exp_lat = exp_hit ? 0 : 2 * W + 1;
      read = rd; write = wr; address = a; writedata = wd;
      #1;
      lat = 0;
      while (SRAM_NOT_READY && lat < 40) begin
         if (lat >= 1 && lat <= 2 * W) begin
            exp_sa = 18'(k * 2 + ((lat > W) ? 1 : 0));
            check("sram_addr", 32'(SRAMaddress), 32'(exp_sa));
            check("wen", 32'(SRAMWEn), 32'(!wr));
            check("oe", 32'(SRAMOE), 32'(wr));
            if (wr)
               check("wdata_bus", 32'(SRAMdata), 32'((lat > W) ? wd[31:16] : wd[15:0]));
         end else begin
            check("idle_wen", 32'(SRAMWEn), 32'd1);
            check("idle_oe", 32'(SRAMOE), 32'd1);
         end
         @(negedge clk);
         lat++;
         if (scramble && lat == 1) begin
            address   = $urandom;
            writedata = $urandom;
         end
      end
      check("latency", lat, exp_lat);
      check("done_wen", 32'(SRAMWEn), 32'd1);
      check("done_oe", 32'(SRAMOE), 32'd1);
      check("done_bus", 32'(SRAMdata), 32'(IDLE_BUS));
      if (wr) begin
         mdl[k] = wd;
         if (mdl_cv && mdl_tag == a[31:2]) mdl_cdata = wd;
      end else begin
         exp_rd   = exp_hit ? mdl_cdata : (mdl.exists(k) ? mdl[k] : 32'h0);
         mdl_last = exp_rd;
         mdl_cv   = 1'b1;
         mdl_tag  = a[31:2];
         mdl_cdata = exp_rd;
      end
      check("readdata", readdata, mdl_last);
      @(posedge clk);
      #1;
      read = 1'b0; write = 1'b0;
      @(negedge clk);
      check("readdata_hold", readdata, mdl_last);
   endtask

   initial begin
      int          k;
      logic        rd;
      logic        wr;
      logic [31:0] a;

      tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0000_0000};
      tbl[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
      tbl[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678};
      tbl[4] = '{1'b0, 1'b1, 32'd1024, 32'h00000001, 32'h12345678};
      tbl[5] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h00000001};
      tbl[6] = '{1'b0, 1'b1, 32'd0,    32'hA5A50F0F, 32'h00000001};
      tbl[7] = '{1'b1, 1'b0, 32'd0,    32'h0,        32'hA5A50F0F};

      mdl_last = 32'h0; mdl_cv = 1'b0; mdl_tag = '0; mdl_cdata = '0;
      rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      repeat (2) @(negedge clk);
      check("rst_not_ready", 32'(SRAM_NOT_READY), 32'd0);
      check("rst_wen", 32'(SRAMWEn), 32'd1);
      check("rst_oe", 32'(SRAMOE), 32'd1);
      check("rst_readdata", readdata, 32'h0);
      check("rst_bus", 32'(SRAMdata), 32'(IDLE_BUS));
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, 1'b0);
         check("table_readdata", readdata, tbl[i].exp_rd);
      end

      // Reset during the HIGH phase of a write: no retry, bus released, readdata cleared.
      k = widx(BASE + 32'd400);
      write = 1'b1; address = BASE + 32'd400; writedata = 32'hCAFEF00D;
      repeat (W + 1) @(negedge clk);
      check("pre_rst_high_addr", 32'(SRAMaddress), 32'(18'(k * 2 + 1)));
      check("pre_rst_high_wen", 32'(SRAMWEn), 32'd0);
      rst = 1'b1; write = 1'b0;
      @(negedge clk);
      check("midrst_not_ready", 32'(SRAM_NOT_READY), 32'd0);
      check("midrst_wen", 32'(SRAMWEn), 32'd1);
      check("midrst_oe", 32'(SRAMOE), 32'd1);
      check("midrst_bus", 32'(SRAMdata), 32'(IDLE_BUS));
      check("midrst_readdata", readdata, 32'h0);
      rst = 1'b0;
      mdl_last = 32'h0; mdl_cv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_retry_wen", 32'(SRAMWEn), 32'd1);
         check("no_retry_busy", 32'(SRAM_NOT_READY), 32'd0);
      end

      for (int i = 0; i < 60; i++) begin
         a  = BASE + 32'(4 * $urandom_range(0, 63));
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if (!rd && !wr) wr = 1'b1;
         if (rd && !wr && !mdl.exists(widx(a))) wr = 1'b1;
         access(rd, wr, a, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
